// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if -- aux-unit write request channel into the writeback arbiter.
//   a_valid : aux unit has a write to retire
//   a_ready : arbiter accepts the request this cycle (a_valid & a_ready)
//   a_waddr : aux destination register
//   a_wdata : aux write data
// Modports: master = aux unit side, slave = arbiter side.
interface wb_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;

  modport master (output a_valid, output a_waddr, output a_wdata, input a_ready);
  modport slave  (input a_valid, input a_waddr, input a_wdata, output a_ready);
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter -- single regfile write port shared between the pipeline
// writeback (always wins, never stalled) and a queue of aux-unit writes
// (divider / long load) that retire in acceptance order when the pipeline
// is idle. Queued entries whose destination is overwritten by a later
// pipeline write are killed (WAW) and retire without writing.
//
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   p_we/p_waddr/p_wdata: pipeline writeback
//   aux                 : aux request channel (wb_arbiter_if.slave)
//   we/waddr/wdata      : regfile write port (combinational)
//   chk_addr1/2         : decode source registers
//   chk_pend1/2         : source has a live queued aux write
//   q_level             : entries queued (live or dead)
//
// Optional build macro: WB_ARBITER_BYPASS_EN -- with the pipeline idle and
// the queue empty, an aux write goes straight to the regfile the same cycle.
module wb_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p_we,
  input  logic [4:0]              p_waddr,
  input  logic [31:0]             p_wdata,
  wb_arbiter_if.slave             aux,
  output logic                    we,
  output logic [4:0]              waddr,
  output logic [31:0]             wdata,
  input  logic [4:0]              chk_addr1,
  input  logic [4:0]              chk_addr2,
  output logic                    chk_pend1,
  output logic                    chk_pend2,
  output logic [$clog2(DEPTH):0]  q_level
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;

  logic w_pipe_wr;
  logic w_pop;
  logic w_push;
  logic w_accept;
  logic w_bypass;
  logic w_head_live;
  logic w_pend1;
  logic w_pend2;

  // All outputs are gated by rst so they read zero while reset is held,
  // even though the pipeline/aux inputs may still be toggling.
  assign w_pipe_wr   = rst & p_we & (p_waddr != '0);
  assign w_pop       = rst & ~w_pipe_wr & (r_level != '0);
  assign w_head_live = r_live[r_rptr];
  assign aux.a_ready = rst & ((r_level != LVL_FULL) | w_pop);
  assign w_accept    = aux.a_valid & aux.a_ready;

`ifdef WB_ARBITER_BYPASS_EN
  assign w_bypass = rst & ~w_pipe_wr & (r_level == '0) & aux.a_valid & (aux.a_waddr != '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Writes to r0 are consumed without occupying a slot.
  assign w_push  = w_accept & (aux.a_waddr != '0) & ~w_bypass;
  assign q_level = r_level;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (w_pipe_wr) begin
      we    = 1'b1;
      waddr = p_waddr;
      wdata = p_wdata;
    end else if (w_pop && w_head_live) begin
      we    = 1'b1;
      waddr = r_addr[r_rptr];
      wdata = r_data[r_rptr];
    end else if (w_bypass) begin
      we    = 1'b1;
      waddr = aux.a_waddr;
      wdata = aux.a_wdata;
    end
  end

  // Live bits are cleared on pop, so a set live bit always marks an
  // occupied slot and no occupancy mask is needed here.
  always_comb begin
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_live[AW'(i)] && (r_addr[AW'(i)] == chk_addr1)) w_pend1 = 1'b1;
      if (r_live[AW'(i)] && (r_addr[AW'(i)] == chk_addr2)) w_pend2 = 1'b1;
    end
    chk_pend1 = rst & w_pend1 & (chk_addr1 != '0);
    chk_pend2 = rst & w_pend2 & (chk_addr2 != '0);
  end

  // Ordering matters: kill, then pop-clear, then push-set. A push into the
  // slot being popped (full queue) or with the address being killed must
  // end up live, since the aux write is the younger one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_live  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_pipe_wr && (r_addr[AW'(i)] == p_waddr)) r_live[AW'(i)] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_rptr] <= 1'b0;
        r_rptr         <= r_rptr + 1'b1;
      end
      if (w_push) begin
        r_live[r_wptr] <= 1'b1;
        r_wptr         <= r_wptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Payload storage needs no reset; only live bits and pointers qualify it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= aux.a_waddr;
      r_data[r_wptr] <= aux.a_wdata;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter -- directed self-checking bench for wb_arbiter (DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_we = 1'b0;
  logic [4:0]  p_waddr = '0;
  logic [31:0] p_wdata = '0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  chk_addr1 = '0;
  logic [4:0]  chk_addr2 = '0;
  logic        chk_pend1;
  logic        chk_pend2;
  logic [2:0]  q_level;

  int total = 0;
  int bad   = 0;

  wb_arbiter_if aux_if ();

  wb_arbiter #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .p_we      (p_we),
    .p_waddr   (p_waddr),
    .p_wdata   (p_wdata),
    .aux       (aux_if.slave),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_pend1 (chk_pend1),
    .chk_pend2 (chk_pend2),
    .q_level   (q_level)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    @(posedge clk);
    #1;
    p_we           = pwe;
    p_waddr        = pa;
    p_wdata        = pd;
    aux_if.a_valid = av;
    aux_if.a_waddr = aa;
    aux_if.a_wdata = ad;
    @(negedge clk);
  endtask

  task automatic test_reset();
    p_we = 1'b1; p_waddr = 5'd5; p_wdata = 32'h55;
    aux_if.a_valid = 1'b1; aux_if.a_waddr = 5'd7; aux_if.a_wdata = 32'h11;
    chk_addr1 = 5'd7;
    #2 rst = 1'b0;
    @(negedge clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0h exp=0", we); end
    total++; if (waddr !== 5'd0) begin bad++; $display("FAIL rst_waddr got=%0h exp=0", waddr); end
    total++; if (wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%0h exp=0", wdata); end
    total++; if (aux_if.a_ready !== 1'b0) begin bad++; $display("FAIL rst_a_ready got=%0h exp=0", aux_if.a_ready); end
    total++; if (q_level !== 3'd0) begin bad++; $display("FAIL rst_q_level got=%0d exp=0", q_level); end
    total++; if (chk_pend1 !== 1'b0) begin bad++; $display("FAIL rst_chk_pend1 got=%0h exp=0", chk_pend1); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    p_we = 1'b0; aux_if.a_valid = 1'b0;
    @(negedge clk);
    total++; if (aux_if.a_ready !== 1'b1) begin bad++; $display("FAIL rel_a_ready got=%0h exp=1", aux_if.a_ready); end
    total++; if (q_level !== 3'd0) begin bad++; $display("FAIL rel_q_level got=%0d exp=0", q_level); end
  endtask

  task automatic test_priority();
    chk_addr1 = 5'd7; chk_addr2 = 5'd8;
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd7, 32'h11);
    total++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h55) begin bad++; $display("FAIL prio_c1 got=%0h/%0d/%0h exp=1/5/55", we, waddr, wdata); end
    total++; if (aux_if.a_ready !== 1'b1) begin bad++; $display("FAIL prio_ready got=%0h exp=1", aux_if.a_ready); end
    drive(1'b1, 5'd5, 32'h56, 1'b1, 5'd8, 32'h22);
    total++; if (waddr !== 5'd5 || wdata !== 32'h56) begin bad++; $display("FAIL prio_c2 got=%0d/%0h exp=5/56", waddr, wdata); end
    total++; if (q_level !== 3'd1 || chk_pend1 !== 1'b1) begin bad++; $display("FAIL prio_c2_q got=%0d/%0h exp=1/1", q_level, chk_pend1); end
    drive(1'b1, 5'd5, 32'h57, 1'b0, 5'd0, 32'h0);
    total++; if (waddr !== 5'd5 || q_level !== 3'd2 || chk_pend2 !== 1'b1) begin bad++; $display("FAIL prio_c3 got=%0d/%0d/%0h exp=5/2/1", waddr, q_level, chk_pend2); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h11) begin bad++; $display("FAIL prio_r7 got=%0h/%0d/%0h exp=1/7/11", we, waddr, wdata); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (we !== 1'b1 || waddr !== 5'd8 || wdata !== 32'h22) begin bad++; $display("FAIL prio_r8 got=%0h/%0d/%0h exp=1/8/22", we, waddr, wdata); end
    total++; if (q_level !== 3'd1 || chk_pend1 !== 1'b0) begin bad++; $display("FAIL prio_r8_q got=%0d/%0h exp=1/0", q_level, chk_pend1); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (we !== 1'b0 || q_level !== 3'd0) begin bad++; $display("FAIL prio_end got=%0h/%0d exp=0/0", we, q_level); end
  endtask

  task automatic test_full();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'd5, 32'h55, 1'b1, 5'(9 + k), 32'(k));
      total++; if (aux_if.a_ready !== 1'b1) begin bad++; $display("FAIL full_acc%0d got=%0h exp=1", k, aux_if.a_ready); end
    end
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd14, 32'd5);
    total++; if (q_level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", q_level); end
    total++; if (aux_if.a_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0h exp=0", aux_if.a_ready); end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'd5);
    total++; if (we !== 1'b1 || waddr !== 5'd10 || wdata !== 32'd1) begin bad++; $display("FAIL full_pop got=%0h/%0d/%0h exp=1/10/1", we, waddr, wdata); end
    total++; if (aux_if.a_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready got=%0h exp=1", aux_if.a_ready); end
    drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
    total++; if (q_level !== 3'd4 || waddr !== 5'd5) begin bad++; $display("FAIL full_pushpop got=%0d/%0d exp=4/5", q_level, waddr); end
    for (int k = 11; k <= 14; k++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      total++; if (we !== 1'b1 || waddr !== 5'(k) || wdata !== 32'(k - 9)) begin bad++; $display("FAIL full_drain%0d got=%0h/%0d/%0h exp=1/%0d/%0h", k, we, waddr, wdata, k, k - 9); end
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (we !== 1'b0 || q_level !== 3'd0) begin bad++; $display("FAIL full_empty got=%0h/%0d exp=0/0", we, q_level); end
  endtask

  task automatic test_waw();
    chk_addr1 = 5'd9;
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd9, 32'hAA);
    drive(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'h0);
    total++; if (chk_pend1 !== 1'b1) begin bad++; $display("FAIL waw_pend_before got=%0h exp=1", chk_pend1); end
    total++; if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'hBB) begin bad++; $display("FAIL waw_pipe got=%0h/%0d/%0h exp=1/9/bb", we, waddr, wdata); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (chk_pend1 !== 1'b0) begin bad++; $display("FAIL waw_pend_after got=%0h exp=0", chk_pend1); end
    total++; if (we !== 1'b0 || q_level !== 3'd1) begin bad++; $display("FAIL waw_dead_pop got=%0h/%0d exp=0/1", we, q_level); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (we !== 1'b0 || q_level !== 3'd0) begin bad++; $display("FAIL waw_empty got=%0h/%0d exp=0/0", we, q_level); end
    // aux push concurrent with a matching pipeline write stays live
    chk_addr1 = 5'd6;
    drive(1'b1, 5'd6, 32'h1, 1'b1, 5'd6, 32'h2);
    total++; if (waddr !== 5'd6 || wdata !== 32'h1) begin bad++; $display("FAIL waw_same_pipe got=%0d/%0h exp=6/1", waddr, wdata); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (chk_pend1 !== 1'b1) begin bad++; $display("FAIL waw_same_pend got=%0h exp=1", chk_pend1); end
    total++; if (we !== 1'b1 || waddr !== 5'd6 || wdata !== 32'h2) begin bad++; $display("FAIL waw_same_aux got=%0h/%0d/%0h exp=1/6/2", we, waddr, wdata); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (q_level !== 3'd0 || chk_pend1 !== 1'b0) begin bad++; $display("FAIL waw_same_end got=%0d/%0h exp=0/0", q_level, chk_pend1); end
  endtask

  task automatic test_bypass();
    chk_addr1 = 5'd3;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h5);
`ifdef WB_ARBITER_BYPASS_EN
    total++; if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h5) begin bad++; $display("FAIL byp_direct got=%0h/%0d/%0h exp=1/3/5", we, waddr, wdata); end
    total++; if (chk_pend1 !== 1'b0) begin bad++; $display("FAIL byp_pend got=%0h exp=0", chk_pend1); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (we !== 1'b0 || q_level !== 3'd0) begin bad++; $display("FAIL byp_after got=%0h/%0d exp=0/0", we, q_level); end
`else
    total++; if (we !== 1'b0 || aux_if.a_ready !== 1'b1) begin bad++; $display("FAIL byp_accept got=%0h/%0h exp=0/1", we, aux_if.a_ready); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (q_level !== 3'd1 || chk_pend1 !== 1'b1) begin bad++; $display("FAIL byp_queued got=%0d/%0h exp=1/1", q_level, chk_pend1); end
    total++; if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h5) begin bad++; $display("FAIL byp_write got=%0h/%0d/%0h exp=1/3/5", we, waddr, wdata); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (we !== 1'b0 || q_level !== 3'd0) begin bad++; $display("FAIL byp_after got=%0h/%0d exp=0/0", we, q_level); end
`endif
  endtask

  task automatic test_zero_reg();
    chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL zero_we got=%0h exp=0", we); end
    total++; if (aux_if.a_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%0h exp=1", aux_if.a_ready); end
    total++; if (chk_pend1 !== 1'b0 || chk_pend2 !== 1'b0) begin bad++; $display("FAIL zero_pend got=%0h/%0h exp=0/0", chk_pend1, chk_pend2); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (q_level !== 3'd0 || we !== 1'b0) begin bad++; $display("FAIL zero_queue got=%0d/%0h exp=0/0", q_level, we); end
  endtask

  task automatic test_reset_mid();
    chk_addr2 = 5'd20;
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd20, 32'h7);
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd21, 32'h8);
    drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
    total++; if (q_level !== 3'd2 || chk_pend2 !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%0h exp=2/1", q_level, chk_pend2); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    p_we = 1'b0;
    @(negedge clk);
    total++; if (q_level !== 3'd0 || we !== 1'b0 || aux_if.a_ready !== 1'b0 || chk_pend2 !== 1'b0) begin bad++; $display("FAIL mid_rst got=%0d/%0h/%0h/%0h exp=0/0/0/0", q_level, we, aux_if.a_ready, chk_pend2); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (q_level !== 3'd0 || we !== 1'b0 || aux_if.a_ready !== 1'b1 || chk_pend2 !== 1'b0) begin bad++; $display("FAIL mid_rel got=%0d/%0h/%0h/%0h exp=0/0/1/0", q_level, we, aux_if.a_ready, chk_pend2); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL mid_nowrite got=%0h exp=0", we); end
  endtask

  initial begin
    aux_if.a_valid = 1'b0;
    aux_if.a_waddr = '0;
    aux_if.a_wdata = '0;
    test_reset();
    test_priority();
    test_full();
    test_waw();
    test_bypass();
    test_zero_reg();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, aux queue entries (power of two, 2..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-004 p_we  input  1  pipeline writeback valid; never stalled.
REQ-005 p_waddr  input  5  pipeline destination register.
REQ-006 p_wdata  input  32  pipeline write data.
REQ-007 a_valid  input  1  aux-unit (divider/long load) write request.
REQ-008 a_ready  output  1  aux request accepted this cycle when a_valid & a_ready.
REQ-009 a_waddr  input  5  aux destination register.
REQ-010 a_wdata  input  32  aux write data.
REQ-011 we  output  1  regfile write enable.
REQ-012 waddr  output  5  regfile write address.
REQ-013 wdata  output  32  regfile write data.
REQ-014 chk_addr1, chk_addr2  input  5  decode-stage source registers to check.
REQ-015 chk_pend1, chk_pend2  output  1  source has a live queued aux write (decode stall).
REQ-016 q_level  output  log2(DEPTH)+1  live-or-dead entries currently queued.

Function
REQ-017 we/waddr/wdata SHALL be combinational from current inputs and queue head (regfile captures on clk).
REQ-018 Priority: p_we=1 with p_waddr!=0 SHALL drive we=1, waddr=p_waddr, wdata=p_wdata; queue not popped.
REQ-019 p_we=1 with p_waddr=0 SHALL be dropped (we=0) and counts as pipeline idle.
REQ-020 Pipeline idle and queue head live SHALL drive head onto write port and pop it at clk edge.
REQ-021 Pipeline idle and queue head dead (killed) SHALL pop head with we=0.
REQ-022 Queue is FIFO; aux writes retire in acceptance order.
REQ-023 a_ready = (q_level < DEPTH) | (pop this cycle); a push and pop in the same cycle SHALL both occur, level unchanged.
REQ-024 Accepted aux request with a_waddr=0 SHALL NOT be queued (consumed, no write).
REQ-025 WAW kill: pipeline write (p_we=1, p_waddr!=0) SHALL clear the live bit of every queued entry with matching address at that clk edge.
REQ-026 An aux request pushed in the same cycle as a matching pipeline write SHALL be queued live (aux is younger).
REQ-027 chk_pendN = 1 iff chkaddrN!=0 and any queued entry is live with matching address; an entry being killed or popped this cycle still counts (combinational on current state).
REQ-028 Pointers SHALL wrap modulo DEPTH; q_level never exceeds DEPTH nor goes below 0.
REQ-029 Single-write-port: at most one regfile write per cycle, always.

Reset
REQ-030 rst=0 SHALL asynchronously empty the queue: pointers 0, q_level=0, all live bits 0.
REQ-031 During reset: we=0, waddr=0, wdata=0, a_ready=0, chk_pend1/2=0.
REQ-032 Reset mid-operation SHALL discard all queued entries with no further writes; first accept possible on the first clk edge after rst deasserts.

Configuration
REQ-033 Macro WB_ARBITER_BYPASS_EN.
REQ-034 Defined: with pipeline idle and queue empty, a valid aux request (a_waddr!=0) SHALL be written directly the same cycle (we=1, a_waddr/a_wdata) and not queued; chk_pend unaffected.
REQ-035 Undefined: every aux write SHALL pass through the queue (minimum one cycle from accept to write).

Verification
REQ-036 Reset: rst=0 with traffic -> we=0, q_level=0, a_ready=0; after release a_ready=1.
REQ-037 Priority: p_we=1 on r5 every cycle, aux pushes r7=0x11,r8=0x22 -> no aux writes while pipe busy; after p_we drops, r7 then r8 written on consecutive cycles.
REQ-038 Full: DEPTH=4, pipe busy, 5 aux requests -> 4 accepted, a_ready=0 on 5th, q_level=4; one pipe-idle cycle -> pop and 5th accepted same cycle.
REQ-039 WAW: aux r9=0xAA queued, pipe writes r9=0xBB -> chk_pend(r9) falls next cycle, head popped with we=0, regfile r9 stays 0xBB.
REQ-040 Bypass: queue empty, pipe idle, aux r3=0x5 -> with macro we=1 same cycle, q_level=0; without macro q_level=1 then write next cycle.
REQ-041 Zero reg: p_waddr=0 and a_waddr=0 requests -> no write, no queue entry, chk_pend(0)=0.
